fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  PC register, next-PC selection and IF/ID pipeline register of the 5-stage MIPS core.
//  - Drives the instruction-memory address and latches the fetched word into D.
//  - Instr_D[15:0] feeds the immediate extender; Instr_D also feeds the controller and register file.
//  - Branch/jump targets are resolved in D with one architectural delay slot: no flush on taken branch.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value after reset
//  NOP_WORD   32'h0000_0000  word loaded into Instr_D on reset or flush (sll $0,$0,0)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-low reset
//  Stall       in   1   hazard unit: hold PC_F and the IF/ID register
//  Flush       in   1   load a bubble into IF/ID (exception / eret redirect)
//  NPCOp       in   2   0: PC+4, 1: branch, 2: j/jal, 3: jr
//  BrTaken     in   1   branch compare result from D; used only when NPCOp==1
//  JrTarget    in   32  forwarded rs value for jr/jalr
//  Instr_F     in   32  word read from instruction memory at PC_F
//  PC_F        out  32  current fetch address
//  Instr_D     out  32  latched instruction
//  PC_D        out  32  latched PC of Instr_D
//  PC8_D       out  32  PC_D+8 (jal/jalr link value)
//  Valid_D     out  1   1 = Instr_D is a real fetched instruction, 0 = bubble
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - PC_F=RESET_PC, Instr_D=NOP_WORD, PC_D=0, Valid_D=0.
//  - PC8_D = PC_D+8 is always combinational, so it reads 8 during reset.
//  - Reset overrides Stall and Flush. A reset asserted mid-stream discards the in-flight IF/ID content.
//  Next-PC (combinational, all adds mod 2^32, wrap-around silent):
//  - NPCOp 0: PC_F+4
//  - NPCOp 1: BrTaken ? PC_D+4+{{14{Instr_D[15]}},Instr_D[15:0],2'b00} : PC_F+4
//  - NPCOp 2: {PC_D[31:28],Instr_D[25:0],2'b00}
//  - NPCOp 3: JrTarget, used unmodified
//  - NPCOp values 1-3 reference PC_D/Instr_D, i.e. the instruction in D; PC_F is then the delay slot.
//  Each posedge with reset==1:
//  - Stall==0 -> PC_F<=NPC; IF/ID <= {Instr_F, PC_F, Valid=1}.
//  - Stall==1 -> PC_F and IF/ID hold their values, and NPCOp is ignored.
//  - Flush==1 -> IF/ID <= {NOP_WORD, PC_D held, Valid=0}, regardless of Stall.
//    PC_F still follows the Stall rule, so Stall+Flush clears D and freezes PC.
//  Latency: one cycle from PC_F to Instr_D/PC_D; a redirect takes effect on the next fetch.
//  No internal state beyond PC_F and the IF/ID register; there is no FSM.
// CONFIGURATION
//  PC_ALIGN_CHK_EN defined:
//  - Adds output ExcAdEL_D (1 bit), registered alongside IF/ID.
//  - When PC_F[1:0]!=0 the IF/ID register latches NOP_WORD, Valid_D=0 and ExcAdEL_D=1, with PC_D=PC_F.
//  - ExcAdEL_D resets to 0 and is cleared by Flush.
//  PC_ALIGN_CHK_EN undefined:
//  - No ExcAdEL_D port.
//  - A misaligned PC_F is passed through unchecked; memory ignores PC_F[1:0].
// TESTING
//  1 Reset held 2 cycles then released, Stall=Flush=0, NPCOp=0 -> PC_F 3000,3004,3008; Instr_D trails PC_F by 1 cycle; Valid_D 0 then 1.
//  2 beq at 0x3008 with imm=16'hFFFE, NPCOp=1, BrTaken=1 -> delay slot 0x300C fetched, then PC_F=0x3004; BrTaken=0 -> PC_F=0x3010.
//  3 jal with index 26'h0000C10 at PC_D=0x3010 -> next PC_F=0x00003040, PC8_D=0x3018; jr with JrTarget=0x3100 -> PC_F=0x3100.
//  4 Stall for 3 cycles at PC_F=0x3020 -> PC_F, Instr_D, PC_D unchanged all 3 cycles; resumes at 0x3024.
//  5 Flush alone -> Instr_D=0, Valid_D=0, PC_F advances; Flush+Stall -> Instr_D=0, PC_F held.
//  6 Reset asserted mid-stall at PC_F=0x3040 -> next cycle PC_F=0x3000, Valid_D=0.
//    With PC_ALIGN_CHK_EN and JrTarget=0x3102 -> ExcAdEL_D=1, Valid_D=0.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: hazard/decode-side bundle for the fetch stage.
// Optional ExcAdEL_D exists only with `define PC_ALIGN_CHK_EN.
interface fetch_if;
  logic        Stall, Flush, BrTaken, Valid_D;
  logic [1:0]  NPCOp;
  logic [31:0] JrTarget, Instr_F, PC_F, Instr_D, PC_D, PC8_D;
`ifdef PC_ALIGN_CHK_EN
  logic        ExcAdEL_D;
`endif
  modport master (
    output Stall, Flush, NPCOp, BrTaken, JrTarget, Instr_F,
`ifdef PC_ALIGN_CHK_EN
    input  ExcAdEL_D,
`endif
    input  PC_F, Instr_D, PC_D, PC8_D, Valid_D
  );
  modport slave (
    input  Stall, Flush, NPCOp, BrTaken, JrTarget, Instr_F,
`ifdef PC_ALIGN_CHK_EN
    output ExcAdEL_D,
`endif
    output PC_F, Instr_D, PC_D, PC8_D, Valid_D
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID register with one delay slot.
// `define PC_ALIGN_CHK_EN turns a misaligned fetch into a bubble flagged by ExcAdEL_D.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic    clk,
  input logic    reset,
  fetch_if.slave bus
);
  logic [31:0] pc_f_q, instr_d_q, pc_d_q, npc_d, br_tgt;
  logic        valid_d_q, misalign;
  // Redirect targets come from the instruction in D; PC_F is its delay slot.
  assign br_tgt = pc_d_q + 32'd4 + {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
  assign npc_d  = bus.NPCOp == 2'd3 ? bus.JrTarget
                : bus.NPCOp == 2'd2 ? {pc_d_q[31:28], instr_d_q[25:0], 2'b00}
                : (bus.NPCOp == 2'd1 && bus.BrTaken) ? br_tgt
                : pc_f_q + 32'd4;
`ifdef PC_ALIGN_CHK_EN
  logic exc_d_q;
  assign misalign      = |pc_f_q[1:0];
  assign bus.ExcAdEL_D = exc_d_q;
`else
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f_q    <= RESET_PC;
      instr_d_q <= NOP_WORD;
      pc_d_q    <= '0;
      valid_d_q <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      exc_d_q   <= 1'b0;
`endif
    end else begin
      if (!bus.Stall) pc_f_q <= npc_d;
      if (bus.Flush) begin
        instr_d_q <= NOP_WORD;
        valid_d_q <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
        exc_d_q   <= 1'b0;
`endif
      end else if (!bus.Stall) begin
        instr_d_q <= misalign ? NOP_WORD : bus.Instr_F;
        pc_d_q    <= pc_f_q;
        valid_d_q <= !misalign;
`ifdef PC_ALIGN_CHK_EN
        exc_d_q   <= misalign;
`endif
      end
    end
  end
  assign bus.PC_F    = pc_f_q;
  assign bus.Instr_D = instr_d_q;
  assign bus.PC_D    = pc_d_q;
  assign bus.PC8_D   = pc_d_q + 32'd8;
  assign bus.Valid_D = valid_d_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; a driver predicts each edge, a negedge monitor compares.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  fetch_if bus();
  fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] pc, ir, pcd, pc8;
    logic        v, exc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_pc = 32'h3000, m_ir = 32'h0, m_pcd = 32'h0;
  logic        m_v = 1'b0, m_exc = 1'b0;
`ifdef PC_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: one architectural clock of the fetch stage, computed from the rules
  task automatic cyc(input logic rst, input logic st, input logic fl, input logic [1:0] op,
                     input logic br, input logic [31:0] jr, input logic [31:0] ir);
    logic [31:0] tgt;
    reset = rst; bus.Stall = st; bus.Flush = fl; bus.NPCOp = op;
    bus.BrTaken = br; bus.JrTarget = jr; bus.Instr_F = ir;
    if (op == 2'd1 && br) tgt = m_pcd + 32'd4 + 32'(int'($signed(m_ir[15:0])) * 4);
    else if (op == 2'd2) tgt = (m_pcd & 32'hF000_0000) | (32'(m_ir[25:0]) << 2);
    else if (op == 2'd3) tgt = jr;
    else tgt = m_pc + 32'd4;
    if (!rst) begin
      m_pc = 32'h3000; m_ir = 32'h0; m_pcd = 32'h0; m_v = 1'b0; m_exc = 1'b0;
    end else begin
      if (fl) begin
        m_ir = 32'h0; m_v = 1'b0; m_exc = 1'b0;
      end else if (!st) begin
        m_pcd = m_pc;
        if (CHK && m_pc[1:0] != 2'b00) begin
          m_ir = 32'h0; m_v = 1'b0; m_exc = 1'b1;
        end else begin
          m_ir = ir; m_v = 1'b1; m_exc = 1'b0;
        end
      end
      if (!st) m_pc = tgt;
    end
    @(posedge clk);
    exp_q.push_back('{m_pc, m_ir, m_pcd, m_pcd + 32'd8, m_v, m_exc});
    #2;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("PC_F", bus.PC_F, e.pc);
      chk("Instr_D", bus.Instr_D, e.ir);
      chk("PC_D", bus.PC_D, e.pcd);
      chk("PC8_D", bus.PC8_D, e.pc8);
      chk("Valid_D", {31'd0, bus.Valid_D}, {31'd0, e.v});
`ifdef PC_ALIGN_CHK_EN
      chk("ExcAdEL_D", {31'd0, bus.ExcAdEL_D}, {31'd0, e.exc});
`endif
    end
  end

  initial begin
    logic [31:0] w;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.NPCOp = 2'd0; bus.BrTaken = 1'b0;
    bus.JrTarget = 32'h0; bus.Instr_F = 32'h0;
    // 1: reset then sequential fetch
    cyc(0, 0, 0, 0, 0, 0, 32'h1111_1111);
    cyc(0, 0, 0, 0, 0, 0, 32'h2222_2222);
    chk("rst_pc", bus.PC_F, 32'h3000);
    chk("rst_pc8", bus.PC8_D, 32'h8);
    cyc(1, 0, 0, 0, 0, 0, 32'hA000_0000);
    chk("t1_pc", bus.PC_F, 32'h3004);
    chk("t1_v", {31'd0, bus.Valid_D}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 32'hA000_0004);
    chk("t1_pc2", bus.PC_F, 32'h3008);
    chk("t1_ird", bus.Instr_D, 32'hA000_0004);
    // 2: beq imm=FFFE at 0x3008, taken then not taken
    cyc(1, 0, 0, 0, 0, 0, 32'h1000_FFFE);
    cyc(1, 0, 0, 1, 1, 0, 32'hD5D5_0001);
    chk("t2_taken", bus.PC_F, 32'h3004);
    chk("t2_slot", bus.PC_D, 32'h300C);
    cyc(1, 0, 0, 0, 0, 0, 32'h0000_0001);
    cyc(1, 0, 0, 0, 0, 0, 32'h1000_FFFE);
    cyc(1, 0, 0, 1, 0, 0, 32'h0000_0002);
    chk("t2_nt", bus.PC_F, 32'h3010);
    // 3: jal then jr
    cyc(1, 0, 0, 0, 0, 0, 32'h0C00_0C10);
    chk("t3_pc8", bus.PC8_D, 32'h3018);
    cyc(1, 0, 0, 2, 0, 0, 32'h0000_0003);
    chk("t3_jal", bus.PC_F, 32'h3040);
    cyc(1, 0, 0, 0, 0, 0, 32'h03E0_0008);
    cyc(1, 0, 0, 3, 0, 32'h3100, 32'h0000_0004);
    chk("t3_jr", bus.PC_F, 32'h3100);
    // 4: stall 3 cycles at 0x3020
    cyc(1, 0, 0, 3, 0, 32'h3020, 32'h0000_0005);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 2'(i + 1), 1, 32'h5000, 32'hBEEF_0000);
    chk("t4_hold", bus.PC_F, 32'h3020);
    cyc(1, 0, 0, 0, 0, 0, 32'h0000_0006);
    chk("t4_resume", bus.PC_F, 32'h3024);
    // 5: flush alone, then flush+stall
    cyc(1, 0, 1, 0, 0, 0, 32'h0000_0007);
    chk("t5_fl_ir", bus.Instr_D, 32'h0);
    chk("t5_fl_pc", bus.PC_F, 32'h3028);
    cyc(1, 1, 1, 0, 0, 0, 32'h0000_0008);
    chk("t5_flst_pc", bus.PC_F, 32'h3028);
    // 6: reset mid-stall at 0x3040
    cyc(1, 0, 0, 3, 0, 32'h3040, 32'h0000_0009);
    cyc(1, 1, 0, 0, 0, 0, 32'h0000_000A);
    cyc(0, 1, 0, 0, 0, 0, 32'h0000_000B);
    chk("t6_pc", bus.PC_F, 32'h3000);
    chk("t6_v", {31'd0, bus.Valid_D}, 32'd0);
    cyc(1, 0, 0, 3, 0, 32'h3102, 32'h0000_000C);
    cyc(1, 0, 0, 0, 0, 0, 32'h0000_000D);
`ifdef PC_ALIGN_CHK_EN
    chk("t6_exc", {31'd0, bus.ExcAdEL_D}, 32'd1);
    chk("t6_exc_v", {31'd0, bus.Valid_D}, 32'd0);
`else
    chk("t6_pass", bus.Instr_D, 32'h0000_000D);
`endif
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(7) != 0) w[1:0] = 2'b00;
      cyc($urandom_range(63) != 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
          2'($urandom_range(3)), 1'($urandom_range(1)), w, $urandom);
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
